sram_arbiter: RTL and testbench
===============================

# sram_arbiter

Two-port arbiter and access sequencer for the board's asynchronous 16-bit SRAM (20-bit word address, byte lanes). It sits between the SRAM pins and two internal requesters, the FFT header wrapper and the FFT body wrapper. It serialises their single-word reads and writes with round-robin fairness. It generates the CE/OE/WE/LB/UB strobes and the tristate data-bus enable with fixed, contention-free timing.

## Interface
- WAIT_CYCLES, 1: clock cycles the strobes are held in ACCESS (legal range 1–15).
- clk  in  1  system clock; all logic rises on this edge.
- reset_n  in  1  asynchronous active-low reset.
- req0 / req1  in  1  access request, requester 0 / 1; held high until ack.
- we0 / we1  in  1  1 = write, 0 = read; stable while req is high.
- addr0 / addr1  in  20  word address; stable while req is high.
- wdata0 / wdata1  in  16  write data; stable while req is high.
- be0 / be1  in  2  byte enables, bit0 = low byte, bit1 = high byte.
- ack0 / ack1  out  1  one-cycle completion pulse.
- rdata0 / rdata1  out  16  read data; valid in the ack cycle, held until the next read for that port.
- sram_addr  out  20  registered address.
- sram_dq_in  in  16  data bus input (tristate is built at top level).
- sram_dq_out  out  16  data bus output value.
- sram_dq_oe  out  1  data bus drive enable.
- sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n  out  1 each  active-low SRAM strobes.

## Operation
- States:
  - IDLE: no access.
  - ACCESS: strobes active, held WAIT_CYCLES cycles by a down-counter.
  - RECOVER: one cycle, ack issued.
- Arbitration is evaluated in IDLE and in RECOVER.
  - Only one req high: grant that requester.
  - Both high: grant the requester that was not served last. `last` is a 1-bit register that updates on every grant.
  - In RECOVER, the req of the requester just served is ignored. This prevents the held-high req from being serviced twice.
- On grant, the following are registered in the same edge:
  - sram_addr ← addr;
  - sram_dq_out ← wdata;
  - lb_n/ub_n ← ~be;
  - selected port, op type.
  - Next state is ACCESS.
- ACCESS, read:
  - ce_n=0, oe_n=0, we_n=1, dq_oe=0.
  - sram_dq_in is sampled into the selected rdata register on the last ACCESS edge.
- ACCESS, write:
  - ce_n=0, oe_n=1, we_n=0, dq_oe=1.
- RECOVER:
  - we_n=1, oe_n=1.
  - Write: ce_n=0 and dq_oe=1, giving data/address hold after the WE rising edge.
  - Read: ce_n=1, dq_oe=0.
  - The selected ack is 1.
  - Next state is ACCESS if the other requester is pending, else IDLE.
- Invariant: dq_oe and !oe_n are never both 1 in any cycle.
- be = 2'b00 is still a full bus cycle with both byte lanes disabled. The requester receives ack; memory contents are unchanged.
- rdata for a port is unchanged by writes and by the other port's reads.

## Timing
- Reset values (asynchronous, applied immediately):
  - state IDLE, last=1 (requester 0 wins the first tie);
  - all strobes 1, dq_oe=0, ack0=ack1=0;
  - sram_addr=0, sram_dq_out=0, rdata0=rdata1=0.
- Reset mid-access:
  - Strobes are released immediately and the transaction is dropped; no ack is issued.
  - The requester reissues after reset.
- Single access latency: req sampled high in IDLE at edge E. ACCESS occupies cycles E+1 .. E+W, ack is high in cycle E+W+1, and IDLE is reached at E+W+2 (W = WAIT_CYCLES).
- Back-to-back, alternating ports: one access every W+1 cycles; RECOVER moves directly to ACCESS.
- Same-port repeat with req held high: one access every W+2 cycles, because it must pass through IDLE.
- req deasserted before ack: undefined; requesters must not do it. This is asserted in the bench.

## Test plan
- Single write then read, port 0, W=1:
  - Stimulus: write addr=0x12345, wdata=0xBEEF, be=11; then read the same address.
  - Required: we_n low exactly 1 cycle; ack0 at cycle 3 relative to req; rdata0=0xBEEF in its ack cycle.
- Simultaneous req0/req1 after reset:
  - Port 0 served first, port 1 served next with no IDLE cycle between.
  - ack0 then ack1, spaced W+1 cycles apart.
- Both req held high for 8 accesses:
  - Grants strictly alternate 0,1,0,1…; each port receives 4 acks.
- Byte-lane write:
  - Stimulus: write 0xAAAA at addr 5 with be=01, then read addr 5.
  - Required: lb_n=0, ub_n=1 during the write; SRAM model reads 0x??AA (high byte unchanged from its prior value 0x55 → 0x55AA).
- W=3, read:
  - oe_n low for exactly 3 cycles; dq_oe=0 throughout.
  - A bus-contention checker flags no cycle with dq_oe=1 and oe_n=0.
- reset_n pulsed low during ACCESS of a write:
  - All strobes go to 1 and dq_oe to 0 asynchronously; no ack is issued.
  - The next request after reset completes normally.

Source files
------------

// File: rtl/sram_arbiter.sv
// Round-robin arbiter and access sequencer for a 16-bit asynchronous SRAM shared by two requesters.
// Every access runs ACCESS for WAIT_CYCLES cycles, then one RECOVER cycle carrying the ack.
module sram_arbiter #(
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req0,
    input  logic        req1,
    input  logic        we0,
    input  logic        we1,
    input  logic [19:0] addr0,
    input  logic [19:0] addr1,
    input  logic [15:0] wdata0,
    input  logic [15:0] wdata1,
    input  logic [1:0]  be0,
    input  logic [1:0]  be1,
    output logic        ack0,
    output logic        ack1,
    output logic [15:0] rdata0,
    output logic [15:0] rdata1,
    output logic [19:0] sram_addr,
    input  logic [15:0] sram_dq_in,
    output logic [15:0] sram_dq_out,
    output logic        sram_dq_oe,
    output logic        sram_ce_n,
    output logic        sram_oe_n,
    output logic        sram_we_n,
    output logic        sram_lb_n,
    output logic        sram_ub_n,
    output logic [1:0]  state_dbg
);

    // Handshake: reqN rises with weN/addrN/wdataN/beN stable and stays high until the
    // one-cycle ackN; a req still high in its own ack cycle is not granted again there.

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] ACCESS  = 2'd1;
    localparam logic [1:0] RECOVER = 2'd2;
    localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

    logic [1:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        last_q, last_d;
    logic        sel_q, sel_d;
    logic        we_q, we_d;
    logic [19:0] addr_q, addr_d;
    logic [15:0] dq_out_q, dq_out_d;
    logic [1:0]  be_n_q, be_n_d;
    logic [15:0] rdata0_q, rdata0_d;
    logic [15:0] rdata1_q, rdata1_d;

    logic elig0, elig1, gnt_sel, do_grant, in_access, in_recover;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        last_d   = last_q;
        sel_d    = sel_q;
        we_d     = we_q;
        addr_d   = addr_q;
        dq_out_d = dq_out_q;
        be_n_d   = be_n_q;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;

        elig0    = req0 && !(state_q == RECOVER && !sel_q);
        elig1    = req1 && !(state_q == RECOVER && sel_q);
        gnt_sel  = (elig0 && elig1) ? ~last_q : elig1;
        do_grant = (state_q == IDLE || state_q == RECOVER) && (elig0 || elig1);

        case (state_q)
            IDLE: ;
            ACCESS: begin
                if (cnt_q == 4'd0) begin
                    state_d = RECOVER;
                    // Last ACCESS edge: data has been valid on the bus for WAIT_CYCLES cycles.
                    if (!we_q) begin
                        if (sel_q) rdata1_d = sram_dq_in;
                        else       rdata0_d = sram_dq_in;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RECOVER: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (do_grant) begin
            state_d  = ACCESS;
            cnt_d    = CNT_INIT;
            last_d   = gnt_sel;
            sel_d    = gnt_sel;
            we_d     = gnt_sel ? we1 : we0;
            addr_d   = gnt_sel ? addr1 : addr0;
            dq_out_d = gnt_sel ? wdata1 : wdata0;
            be_n_d   = gnt_sel ? ~be1 : ~be0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            cnt_q    <= 4'd0;
            last_q   <= 1'b1;
            sel_q    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= 20'd0;
            dq_out_q <= 16'd0;
            be_n_q   <= 2'b11;
            rdata0_q <= 16'd0;
            rdata1_q <= 16'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            last_q   <= last_d;
            sel_q    <= sel_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            dq_out_q <= dq_out_d;
            be_n_q   <= be_n_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end

    assign in_access  = (state_q == ACCESS);
    assign in_recover = (state_q == RECOVER);

    // Writes keep CE and the bus driven through RECOVER so data/address hold past WE rising.
    assign sram_ce_n   = !(in_access || (in_recover && we_q));
    assign sram_oe_n   = !(in_access && !we_q);
    assign sram_we_n   = !(in_access && we_q);
    assign sram_dq_oe  = (in_access || in_recover) && we_q;
    assign sram_lb_n   = sram_ce_n | be_n_q[0];
    assign sram_ub_n   = sram_ce_n | be_n_q[1];
    assign sram_addr   = addr_q;
    assign sram_dq_out = dq_out_q;
    assign ack0        = in_recover && !sel_q;
    assign ack1        = in_recover && sel_q;
    assign rdata0      = rdata0_q;
    assign rdata1      = rdata1_q;
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: a W=1 instance with a behavioural SRAM for most scenarios,
// plus a W=3 instance for the long read.
module tb_sram_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_n;
    int   checks = 0;
    int   errors = 0;
    int   contention = 0;

    logic        a_req0, a_req1, a_we0, a_we1, a_ack0, a_ack1;
    logic [19:0] a_addr0, a_addr1, a_sram_addr;
    logic [15:0] a_wdata0, a_wdata1, a_rdata0, a_rdata1, a_dq_out;
    logic [15:0] a_dq_in = 16'h0000;
    logic [1:0]  a_be0, a_be1, a_state;
    logic        a_dq_oe, a_ce_n, a_oe_n, a_we_n, a_lb_n, a_ub_n;

    logic        b_req0, b_req1, b_we0, b_we1, b_ack0, b_ack1;
    logic [19:0] b_addr0, b_addr1, b_sram_addr;
    logic [15:0] b_wdata0, b_wdata1, b_rdata0, b_rdata1, b_dq_out;
    logic [15:0] b_dq_in = 16'h0000;
    logic [1:0]  b_be0, b_be1, b_state;
    logic        b_dq_oe, b_ce_n, b_oe_n, b_we_n, b_lb_n, b_ub_n;

    sram_arbiter #(.WAIT_CYCLES(1)) dut_a (
        .clk(clk), .reset_n(reset_n),
        .req0(a_req0), .req1(a_req1), .we0(a_we0), .we1(a_we1),
        .addr0(a_addr0), .addr1(a_addr1), .wdata0(a_wdata0), .wdata1(a_wdata1),
        .be0(a_be0), .be1(a_be1), .ack0(a_ack0), .ack1(a_ack1),
        .rdata0(a_rdata0), .rdata1(a_rdata1), .sram_addr(a_sram_addr),
        .sram_dq_in(a_dq_in), .sram_dq_out(a_dq_out), .sram_dq_oe(a_dq_oe),
        .sram_ce_n(a_ce_n), .sram_oe_n(a_oe_n), .sram_we_n(a_we_n),
        .sram_lb_n(a_lb_n), .sram_ub_n(a_ub_n), .state_dbg(a_state)
    );

    sram_arbiter #(.WAIT_CYCLES(3)) dut_b (
        .clk(clk), .reset_n(reset_n),
        .req0(b_req0), .req1(b_req1), .we0(b_we0), .we1(b_we1),
        .addr0(b_addr0), .addr1(b_addr1), .wdata0(b_wdata0), .wdata1(b_wdata1),
        .be0(b_be0), .be1(b_be1), .ack0(b_ack0), .ack1(b_ack1),
        .rdata0(b_rdata0), .rdata1(b_rdata1), .sram_addr(b_sram_addr),
        .sram_dq_in(b_dq_in), .sram_dq_out(b_dq_out), .sram_dq_oe(b_dq_oe),
        .sram_ce_n(b_ce_n), .sram_oe_n(b_oe_n), .sram_we_n(b_we_n),
        .sram_lb_n(b_lb_n), .sram_ub_n(b_ub_n), .state_dbg(b_state)
    );

    // Behavioural SRAMs: lane-masked writes while CE/WE low, read data driven while CE/OE low.
    logic [15:0] mem_a [logic [19:0]];
    logic [15:0] mem_b [logic [19:0]];
    logic [15:0] cur_a, cur_b;

    function automatic logic [15:0] rd_a(input logic [19:0] ad);
        if (mem_a.exists(ad)) return mem_a[ad];
        return 16'h0000;
    endfunction

    function automatic logic [15:0] rd_b(input logic [19:0] ad);
        if (mem_b.exists(ad)) return mem_b[ad];
        return 16'h0000;
    endfunction

    always @(negedge clk) begin
        if (!a_ce_n && !a_we_n) begin
            cur_a = rd_a(a_sram_addr);
            if (!a_lb_n) cur_a[7:0]  = a_dq_out[7:0];
            if (!a_ub_n) cur_a[15:8] = a_dq_out[15:8];
            mem_a[a_sram_addr] = cur_a;
        end
        if (!b_ce_n && !b_we_n) begin
            cur_b = rd_b(b_sram_addr);
            if (!b_lb_n) cur_b[7:0]  = b_dq_out[7:0];
            if (!b_ub_n) cur_b[15:8] = b_dq_out[15:8];
            mem_b[b_sram_addr] = cur_b;
        end
        a_dq_in = (!a_ce_n && !a_oe_n) ? rd_a(a_sram_addr) : 16'h0000;
        b_dq_in = (!b_ce_n && !b_oe_n) ? rd_b(b_sram_addr) : 16'h0000;
        if (a_dq_oe && !a_oe_n) contention++;
        if (b_dq_oe && !b_oe_n) contention++;
    end

    // A requester must hold req until its ack.
    logic a_req0_p = 1'b0, a_req1_p = 1'b0, a_ack0_p = 1'b0, a_ack1_p = 1'b0;
    always @(negedge clk) begin
        if (reset_n && a_req0_p && !a_req0 && !a_ack0_p) begin
            errors++; $display("FAIL req0_hold: req0 dropped before ack0");
        end
        if (reset_n && a_req1_p && !a_req1 && !a_ack1_p) begin
            errors++; $display("FAIL req1_hold: req1 dropped before ack1");
        end
        a_req0_p = a_req0; a_req1_p = a_req1;
        a_ack0_p = a_ack0; a_ack1_p = a_ack1;
    end

    int          cyc, we_lo, oe_lo, lb_lo, ub_lo;
    logic [15:0] rd;

    // cyc numbers the req-assert cycle as 1, so with W=1 the ack lands in cycle 3.
    task automatic access_a(input int port, input logic we, input logic [19:0] addr,
                            input logic [15:0] d, input logic [1:0] be);
        @(posedge clk); #1;
        if (port == 0) begin
            a_we0 = we; a_addr0 = addr; a_wdata0 = d; a_be0 = be; a_req0 = 1'b1;
        end else begin
            a_we1 = we; a_addr1 = addr; a_wdata1 = d; a_be1 = be; a_req1 = 1'b1;
        end
        cyc = 0; we_lo = 0; oe_lo = 0; lb_lo = 0; ub_lo = 0; rd = 16'hxxxx;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk); @(negedge clk);
            if (!a_we_n) we_lo++;
            if (!a_oe_n) oe_lo++;
            if (!a_lb_n) lb_lo++;
            if (!a_ub_n) ub_lo++;
            if ((port == 0) ? a_ack0 : a_ack1) begin
                cyc = n + 1;
                rd  = (port == 0) ? a_rdata0 : a_rdata1;
                break;
            end
        end
        @(posedge clk); #1;
        if (port == 0) a_req0 = 1'b0; else a_req1 = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if ({a_ce_n, a_oe_n, a_we_n, a_lb_n, a_ub_n} !== 5'b11111) begin
            errors++; $display("FAIL reset_strobes_a: got %b want 11111", {a_ce_n, a_oe_n, a_we_n, a_lb_n, a_ub_n}); end
        checks++; if ({b_ce_n, b_oe_n, b_we_n, b_lb_n, b_ub_n} !== 5'b11111) begin
            errors++; $display("FAIL reset_strobes_b: got %b want 11111", {b_ce_n, b_oe_n, b_we_n, b_lb_n, b_ub_n}); end
        checks++; if ({a_dq_oe, a_ack0, a_ack1} !== 3'b000) begin
            errors++; $display("FAIL reset_oe_ack: got %b want 000", {a_dq_oe, a_ack0, a_ack1}); end
        checks++; if (a_sram_addr !== 20'h0) begin
            errors++; $display("FAIL reset_addr: got %h want 00000", a_sram_addr); end
        checks++; if (a_dq_out !== 16'h0) begin
            errors++; $display("FAIL reset_dq_out: got %h want 0000", a_dq_out); end
        checks++; if ({a_rdata0, a_rdata1} !== 32'h0) begin
            errors++; $display("FAIL reset_rdata: got %h want 00000000", {a_rdata0, a_rdata1}); end
        checks++; if (a_state !== 2'd0) begin
            errors++; $display("FAIL reset_state: got %0d want 0", a_state); end
        reset_n = 1'b1;
    endtask

    task automatic test_simultaneous();
        int n, ack0_n, ack1_n, idle_gap;
        logic drop0, drop1;
        @(posedge clk); #1;
        a_we0 = 1'b1; a_addr0 = 20'h00100; a_wdata0 = 16'h1111; a_be0 = 2'b11;
        a_we1 = 1'b1; a_addr1 = 20'h00200; a_wdata1 = 16'h2222; a_be1 = 2'b11;
        a_req0 = 1'b1; a_req1 = 1'b1;
        n = 0; ack0_n = 0; ack1_n = 0; idle_gap = 0; drop0 = 1'b0; drop1 = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            if (drop0) a_req0 = 1'b0;
            if (drop1) a_req1 = 1'b0;
            drop0 = 1'b0; drop1 = 1'b0;
            if (ack0_n > 0 && ack1_n > 0) break;
            n++;
            @(negedge clk);
            if (a_ack0) begin ack0_n = n; drop0 = 1'b1; end
            if (a_ack1) begin ack1_n = n; drop1 = 1'b1; end
            if (ack0_n > 0 && ack1_n == 0 && a_state == 2'd0) idle_gap = 1;
        end
        a_req0 = 1'b0; a_req1 = 1'b0;
        // Tie after reset goes to port 0; port 1 follows W+1 = 2 edges later.
        checks++; if (ack0_n !== 2) begin
            errors++; $display("FAIL sim_ack0_edge: got %0d want 2", ack0_n); end
        checks++; if (ack1_n !== 4) begin
            errors++; $display("FAIL sim_ack1_edge: got %0d want 4", ack1_n); end
        checks++; if (idle_gap !== 0) begin
            errors++; $display("FAIL sim_no_idle: got %0d want 0", idle_gap); end
        access_a(1, 1'b0, 20'h00200, 16'h0000, 2'b11);
        checks++; if (rd !== 16'h2222) begin
            errors++; $display("FAIL sim_port1_readback: got %h want 2222", rd); end
    endtask

    task automatic test_single();
        access_a(0, 1'b1, 20'h12345, 16'hBEEF, 2'b11);
        checks++; if (cyc !== 3) begin
            errors++; $display("FAIL wr_ack_cycle: got %0d want 3", cyc); end
        checks++; if (we_lo !== 1) begin
            errors++; $display("FAIL wr_we_low: got %0d want 1", we_lo); end
        checks++; if ({oe_lo, lb_lo, ub_lo} !== {32'd0, 32'd2, 32'd2}) begin
            errors++; $display("FAIL wr_oe_lanes: got oe=%0d lb=%0d ub=%0d want 0 2 2", oe_lo, lb_lo, ub_lo); end
        checks++; if (a_sram_addr !== 20'h12345) begin
            errors++; $display("FAIL wr_addr: got %h want 12345", a_sram_addr); end
        access_a(0, 1'b0, 20'h12345, 16'h0000, 2'b11);
        checks++; if (cyc !== 3) begin
            errors++; $display("FAIL rd_ack_cycle: got %0d want 3", cyc); end
        checks++; if (rd !== 16'hBEEF) begin
            errors++; $display("FAIL rd_data: got %h want beef", rd); end
        checks++; if ({oe_lo, we_lo} !== {32'd1, 32'd0}) begin
            errors++; $display("FAIL rd_strobes: got oe=%0d we=%0d want 1 0", oe_lo, we_lo); end
        checks++; if (a_rdata1 !== 16'h2222) begin
            errors++; $display("FAIL rdata1_kept: got %h want 2222", a_rdata1); end
    endtask

    task automatic test_alternate();
        int seq[$];
        int gaps[$];
        int n, last_n, c0, c1;
        logic drop0, drop1;
        // be=00 writes: full bus cycles that must leave memory untouched.
        @(posedge clk); #1;
        a_we0 = 1'b1; a_addr0 = 20'h12345; a_wdata0 = 16'h0000; a_be0 = 2'b00;
        a_we1 = 1'b1; a_addr1 = 20'h12345; a_wdata1 = 16'hFFFF; a_be1 = 2'b00;
        a_req0 = 1'b1; a_req1 = 1'b1;
        n = 0; last_n = 0; drop0 = 1'b0; drop1 = 1'b0;
        for (int k = 0; k < 60; k++) begin
            @(posedge clk); #1;
            if (drop0) a_req0 = 1'b0;
            if (drop1) a_req1 = 1'b0;
            drop0 = 1'b0; drop1 = 1'b0;
            if (!a_req0 && !a_req1) break;
            n++;
            @(negedge clk);
            if (a_ack0 || a_ack1) begin
                if (seq.size() < 8) begin
                    seq.push_back(a_ack1 ? 1 : 0);
                    gaps.push_back(n - last_n);
                    last_n = n;
                end
                if (seq.size() >= 8) begin
                    if (a_ack0) drop0 = 1'b1;
                    if (a_ack1) drop1 = 1'b1;
                end
            end
        end
        a_req0 = 1'b0; a_req1 = 1'b0;
        checks++; if (seq.size() !== 8) begin
            errors++; $display("FAIL alt_count: got %0d want 8", seq.size()); end
        // Port 0 was served last before this test, so the tie goes to port 1 first.
        c0 = 0; c1 = 0;
        for (int i = 0; i < seq.size(); i++) begin
            if (seq[i] == 0) c0++; else c1++;
            checks++; if (seq[i] !== ((i + 1) % 2)) begin
                errors++; $display("FAIL alt_order[%0d]: got %0d want %0d", i, seq[i], (i + 1) % 2); end
            checks++; if (gaps[i] !== 2) begin
                errors++; $display("FAIL alt_gap[%0d]: got %0d want 2", i, gaps[i]); end
        end
        checks++; if ({c0, c1} !== {32'd4, 32'd4}) begin
            errors++; $display("FAIL alt_per_port: got %0d %0d want 4 4", c0, c1); end
        access_a(1, 1'b0, 20'h12345, 16'h0000, 2'b11);
        checks++; if (rd !== 16'hBEEF) begin
            errors++; $display("FAIL be00_unchanged: got %h want beef", rd); end
        checks++; if (a_rdata0 !== 16'hBEEF) begin
            errors++; $display("FAIL rdata0_kept: got %h want beef", a_rdata0); end
    endtask

    task automatic test_byte_lane();
        access_a(0, 1'b1, 20'h00005, 16'hAAAA, 2'b01);
        checks++; if ({lb_lo, ub_lo} !== {32'd2, 32'd0}) begin
            errors++; $display("FAIL lane_strobes: got lb=%0d ub=%0d want 2 0", lb_lo, ub_lo); end
        access_a(0, 1'b0, 20'h00005, 16'h0000, 2'b11);
        checks++; if (rd !== 16'h55AA) begin
            errors++; $display("FAIL lane_readback: got %h want 55aa", rd); end
    endtask

    task automatic test_w3_read();
        int n, oe_cnt, dqoe_cnt;
        logic [15:0] got;
        @(posedge clk); #1;
        b_we0 = 1'b0; b_addr0 = 20'h00007; b_be0 = 2'b11; b_req0 = 1'b1;
        n = 0; oe_cnt = 0; dqoe_cnt = 0; got = 16'hxxxx;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); @(negedge clk);
            if (!b_oe_n) oe_cnt++;
            if (b_dq_oe) dqoe_cnt++;
            if (b_ack0) begin n = k; got = b_rdata0; break; end
        end
        @(posedge clk); #1;
        b_req0 = 1'b0;
        checks++; if (oe_cnt !== 3) begin
            errors++; $display("FAIL w3_oe_low: got %0d want 3", oe_cnt); end
        checks++; if (dqoe_cnt !== 0) begin
            errors++; $display("FAIL w3_dq_oe: got %0d want 0", dqoe_cnt); end
        checks++; if (n !== 4) begin
            errors++; $display("FAIL w3_ack_edge: got %0d want 4", n); end
        checks++; if (got !== 16'h1357) begin
            errors++; $display("FAIL w3_rdata: got %h want 1357", got); end
        checks++; if (contention !== 0) begin
            errors++; $display("FAIL bus_contention: got %0d cycles want 0", contention); end
    endtask

    task automatic test_reset_mid();
        int acks;
        @(posedge clk); #1;
        a_we0 = 1'b1; a_addr0 = 20'h00009; a_wdata0 = 16'h9999; a_be0 = 2'b11; a_req0 = 1'b1;
        @(posedge clk); #2;
        checks++; if ({a_state, a_we_n} !== {2'd1, 1'b0}) begin
            errors++; $display("FAIL mid_in_access: got state=%0d we_n=%b want 1 0", a_state, a_we_n); end
        reset_n = 1'b0; a_req0 = 1'b0;
        #1;
        checks++; if ({a_ce_n, a_oe_n, a_we_n, a_lb_n, a_ub_n, a_dq_oe} !== 6'b111110) begin
            errors++; $display("FAIL mid_release: got %b want 111110", {a_ce_n, a_oe_n, a_we_n, a_lb_n, a_ub_n, a_dq_oe}); end
        acks = 0;
        repeat (3) begin @(negedge clk); if (a_ack0 || a_ack1) acks++; end
        @(posedge clk); #3;
        reset_n = 1'b1;
        repeat (2) begin @(negedge clk); if (a_ack0 || a_ack1) acks++; end
        checks++; if (acks !== 0) begin
            errors++; $display("FAIL mid_no_ack: got %0d want 0", acks); end
        checks++; if (mem_a.exists(20'h00009)) begin
            errors++; $display("FAIL mid_no_write: got %h want unwritten", mem_a[20'h00009]); end
        access_a(0, 1'b1, 20'h00009, 16'h9999, 2'b11);
        checks++; if (cyc !== 3) begin
            errors++; $display("FAIL post_reset_ack: got %0d want 3", cyc); end
        access_a(0, 1'b0, 20'h00009, 16'h0000, 2'b11);
        checks++; if (rd !== 16'h9999) begin
            errors++; $display("FAIL post_reset_read: got %h want 9999", rd); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        a_req0 = 0; a_req1 = 0; a_we0 = 0; a_we1 = 0; a_addr0 = 0; a_addr1 = 0;
        a_wdata0 = 0; a_wdata1 = 0; a_be0 = 0; a_be1 = 0;
        b_req0 = 0; b_req1 = 0; b_we0 = 0; b_we1 = 0; b_addr0 = 0; b_addr1 = 0;
        b_wdata0 = 0; b_wdata1 = 0; b_be0 = 0; b_be1 = 0;
        mem_a[20'h00005] = 16'h5555;
        mem_b[20'h00007] = 16'h1357;
        test_reset();
        test_simultaneous();
        test_single();
        test_alternate();
        test_byte_lane();
        test_w3_read();
        test_reset_mid();
        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
